// File: rtl/pipelined_rv32_core.sv
// Five-stage in-order RV32 integer pipeline (IF/ID/EX/MEM/WB) with internal IMEM, DMEM and register file.
// Define PIPE_PERF_COUNTERS_EN to add the stall_cnt_o / flush_cnt_o performance counter outputs.
module pipelined_rv32_core #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_BYTES = 32,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_BYTES);

  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_LW = 7'h03;
  localparam logic [6:0] OP_SW = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_AND, ALU_MUL, ALU_SRA
  } alu_op_e;

  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] rf   [32];

  logic [31:0] pc;

  logic               vld_p1;
  logic [31:0]        pc_p1;
  logic [31:0]        instr_p1;

  logic               vld_p2;
  logic               regwrite_p2;
  logic               memread_p2;
  logic               memwrite_p2;
  logic               useimm_p2;
  alu_op_e            aluop_p2;
  logic [4:0]         rd_p2;
  logic [4:0]         rs1_p2;
  logic [4:0]         rs2_p2;
  logic signed [31:0] rs1v_p2;
  logic signed [31:0] rs2v_p2;
  logic signed [31:0] imm_p2;

  logic               vld_p3;
  logic               regwrite_p3;
  logic               memread_p3;
  logic               memwrite_p3;
  logic [4:0]         rd_p3;
  logic [31:0]        alu_p3;
  logic [31:0]        stdata_p3;

  logic               vld_p4;
  logic               regwrite_p4;
  logic [4:0]         rd_p4;
  logic [31:0]        wbdata_p4;

  // ID: field extraction and decode
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rd_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  assign opc    = instr_p1[6:0];
  assign rd_id  = instr_p1[11:7];
  assign f3     = instr_p1[14:12];
  assign rs1_id = instr_p1[19:15];
  assign rs2_id = instr_p1[24:20];
  assign f7     = instr_p1[31:25];

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  assign imm_i = {{20{instr_p1[31]}}, instr_p1[31:20]};
  assign imm_s = {{20{instr_p1[31]}}, instr_p1[31:25], instr_p1[11:7]};
  assign imm_b = {{19{instr_p1[31]}}, instr_p1[31], instr_p1[7], instr_p1[30:25],
                  instr_p1[11:8], 1'b0};

  logic               d_valid;
  logic               d_regwrite;
  logic               d_memread;
  logic               d_memwrite;
  logic               d_useimm;
  logic               d_beq;
  logic               d_use_rs1;
  logic               d_use_rs2;
  alu_op_e            d_aluop;
  logic signed [31:0] d_imm;

  always_comb begin
    d_valid    = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_useimm   = 1'b0;
    d_beq      = 1'b0;
    d_use_rs1  = 1'b0;
    d_use_rs2  = 1'b0;
    d_aluop    = ALU_ADD;
    d_imm      = imm_i;
    case (opc)
      OP_R: begin
        d_valid = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: d_aluop = ALU_ADD;
          {7'h20, 3'b000}: d_aluop = ALU_SUB;
          {7'h00, 3'b001}: d_aluop = ALU_SLL;
          {7'h00, 3'b100}: d_aluop = ALU_XOR;
          {7'h00, 3'b111}: d_aluop = ALU_AND;
          {7'h01, 3'b000}: d_aluop = ALU_MUL;
          default:         d_valid = 1'b0;
        endcase
        d_regwrite = d_valid;
        d_use_rs1  = d_valid;
        d_use_rs2  = d_valid;
      end
      OP_I: begin
        if (f3 == 3'b000) begin
          d_valid = 1'b1;
        end else if (f3 == 3'b101 && f7 == 7'h20) begin
          d_valid = 1'b1;
          d_aluop = ALU_SRA;
        end
        d_regwrite = d_valid;
        d_use_rs1  = d_valid;
        d_useimm   = d_valid;
      end
      OP_LW: if (f3 == 3'b010) begin
        d_valid    = 1'b1;
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
        d_use_rs1  = 1'b1;
        d_useimm   = 1'b1;
      end
      OP_SW: if (f3 == 3'b010) begin
        d_valid    = 1'b1;
        d_memwrite = 1'b1;
        d_use_rs1  = 1'b1;
        d_use_rs2  = 1'b1;
        d_useimm   = 1'b1;
        d_imm      = imm_s;
      end
      OP_BR: if (f3 == 3'b000) begin
        d_valid   = 1'b1;
        d_beq     = 1'b1;
        d_use_rs1 = 1'b1;
        d_use_rs2 = 1'b1;
        d_imm     = imm_b;
      end
      default: ;
    endcase
  end

  // Register read with WB->ID bypass so a same-cycle write is seen by ID
  logic        wb_we;
  logic [31:0] rs1v_id;
  logic [31:0] rs2v_id;
  assign wb_we = vld_p4 && regwrite_p4 && (rd_p4 != 5'd0);

  always_comb begin
    rs1v_id = rf[rs1_id];
    rs2v_id = rf[rs2_id];
    if (wb_we && rd_p4 == rs1_id) rs1v_id = wbdata_p4;
    if (wb_we && rd_p4 == rs2_id) rs2v_id = wbdata_p4;
    if (rs1_id == 5'd0) rs1v_id = 32'h0;
    if (rs2_id == 5'd0) rs2v_id = 32'h0;
  end

  logic        stall;
  logic        flush;
  logic [31:0] br_target;
  assign stall = memread_p2 && (rd_p2 != 5'd0) &&
                 ((d_use_rs1 && rd_p2 == rs1_id) || (d_use_rs2 && rd_p2 == rs2_id));
  assign flush     = d_beq && (rs1v_id == rs2v_id) && !stall;
  assign br_target = pc_p1 + d_imm;

  // EX: operand forwarding (EX/MEM wins over MEM/WB) and ALU
  logic               ex_fw;
  logic signed [31:0] fwd_a;
  logic signed [31:0] fwd_b;
  logic signed [31:0] opb_ex;
  logic signed [31:0] alu_ex;
  assign ex_fw = vld_p3 && regwrite_p3 && (rd_p3 != 5'd0);

  always_comb begin
    fwd_a = rs1v_p2;
    fwd_b = rs2v_p2;
    if (ex_fw && rd_p3 == rs1_p2)      fwd_a = alu_p3;
    else if (wb_we && rd_p4 == rs1_p2) fwd_a = wbdata_p4;
    if (ex_fw && rd_p3 == rs2_p2)      fwd_b = alu_p3;
    else if (wb_we && rd_p4 == rs2_p2) fwd_b = wbdata_p4;
    opb_ex = useimm_p2 ? imm_p2 : fwd_b;
    case (aluop_p2)
      ALU_SUB: alu_ex = fwd_a - opb_ex;
      ALU_SLL: alu_ex = fwd_a << opb_ex[4:0];
      ALU_XOR: alu_ex = fwd_a ^ opb_ex;
      ALU_AND: alu_ex = fwd_a & opb_ex;
      ALU_MUL: alu_ex = fwd_a * opb_ex;
      ALU_SRA: alu_ex = fwd_a >>> opb_ex[4:0];
      default: alu_ex = fwd_a + opb_ex;
    endcase
  end

  // MEM: word-aligned little-endian access, address wraps modulo DMEM_BYTES
  logic [DA_W-1:0] dbase;
  logic [31:0]     ld_mem;
  assign dbase  = {alu_p3[DA_W-1:2], 2'b00};
  assign ld_mem = {dmem[dbase | DA_W'(3)], dmem[dbase | DA_W'(2)],
                   dmem[dbase | DA_W'(1)], dmem[dbase]};

  always_ff @(posedge clk_i) begin
    if (!rst_i && vld_p3 && memwrite_p3) begin
      dmem[dbase]            <= stdata_p3[7:0];
      dmem[dbase | DA_W'(1)] <= stdata_p3[15:8];
      dmem[dbase | DA_W'(2)] <= stdata_p3[23:16];
      dmem[dbase | DA_W'(3)] <= stdata_p3[31:24];
    end
  end

  // WB: register file write
  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_we) rf[rd_p4] <= wbdata_p4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= PC_RESET;
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      instr_p1    <= '0;
      vld_p2      <= 1'b0;
      regwrite_p2 <= 1'b0;
      memread_p2  <= 1'b0;
      memwrite_p2 <= 1'b0;
      useimm_p2   <= 1'b0;
      aluop_p2    <= ALU_ADD;
      rd_p2       <= '0;
      rs1_p2      <= '0;
      rs2_p2      <= '0;
      rs1v_p2     <= '0;
      rs2v_p2     <= '0;
      imm_p2      <= '0;
      vld_p3      <= 1'b0;
      regwrite_p3 <= 1'b0;
      memread_p3  <= 1'b0;
      memwrite_p3 <= 1'b0;
      rd_p3       <= '0;
      alu_p3      <= '0;
      stdata_p3   <= '0;
      vld_p4      <= 1'b0;
      regwrite_p4 <= 1'b0;
      rd_p4       <= '0;
      wbdata_p4   <= '0;
    end else begin
      // IF -> IF/ID
      if (!stall) begin
        if (flush)        pc <= br_target;
        else if (start_i) pc <= pc + 32'd4;
        if (flush || !start_i) begin
          vld_p1   <= 1'b0;
          pc_p1    <= '0;
          instr_p1 <= '0;
        end else begin
          vld_p1   <= 1'b1;
          pc_p1    <= pc;
          instr_p1 <= imem[pc[IA_W+1:2]];
        end
      end
      // ID -> ID/EX
      if (stall) begin
        vld_p2      <= 1'b0;
        regwrite_p2 <= 1'b0;
        memread_p2  <= 1'b0;
        memwrite_p2 <= 1'b0;
        useimm_p2   <= 1'b0;
        aluop_p2    <= ALU_ADD;
        rd_p2       <= '0;
        rs1_p2      <= '0;
        rs2_p2      <= '0;
        rs1v_p2     <= '0;
        rs2v_p2     <= '0;
        imm_p2      <= '0;
      end else begin
        vld_p2      <= vld_p1 && d_valid;
        regwrite_p2 <= d_regwrite;
        memread_p2  <= d_memread;
        memwrite_p2 <= d_memwrite;
        useimm_p2   <= d_useimm;
        aluop_p2    <= d_aluop;
        rd_p2       <= rd_id;
        rs1_p2      <= rs1_id;
        rs2_p2      <= rs2_id;
        rs1v_p2     <= rs1v_id;
        rs2v_p2     <= rs2v_id;
        imm_p2      <= d_imm;
      end
      // EX -> EX/MEM
      vld_p3      <= vld_p2;
      regwrite_p3 <= regwrite_p2;
      memread_p3  <= memread_p2;
      memwrite_p3 <= memwrite_p2;
      rd_p3       <= rd_p2;
      alu_p3      <= alu_ex;
      stdata_p3   <= fwd_b;
      // MEM -> MEM/WB
      vld_p4      <= vld_p3;
      regwrite_p4 <= regwrite_p3;
      rd_p4       <= rd_p3;
      wbdata_p4   <= memread_p3 ? ld_mem : alu_p3;
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipelined_rv32_core.sv
// Directed testbench for pipelined_rv32_core: programs are preloaded into IMEM hierarchically
// and architectural state (PC, registers, DMEM) is compared against hand-computed values.
module tb_pipelined_rv32_core;
  logic clk;
  logic rst;
  logic start;
  int   compared;
  int   mismatched;
  int   stalls;
  int   flushes;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipelined_rv32_core #(
    .IMEM_WORDS(256),
    .DMEM_BYTES(32),
    .PC_RESET  (32'h0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start)
`ifdef PIPE_PERF_COUNTERS_EN
    ,
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small assembler helpers
  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] f_srai(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] sh);
    return {7'b0100000, sh, rs1, 3'b101, rd, 7'h13};
  endfunction
  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  // off holds the byte offset bits [12:1] of the branch
  function automatic logic [31:0] f_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:1] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    stalls  = 0;
    flushes = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (dut.stall) stalls++;
      if (dut.flush) flushes++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clear_imem();
    dut.imem[0] = f_addi(5'd20, 5'd0, 12'd1);
    rst   = 1'b0;
    start = 1'b1;
    run(3);
    do_reset();
    compared++; if (dut.pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want %h", dut.pc, 32'h0); end
    compared++; if (dut.instr_p1 !== 32'h0) begin mismatched++; $display("FAIL reset_ifid: got %h want %h", dut.instr_p1, 32'h0); end
    compared++; if ({dut.vld_p2, dut.regwrite_p2, dut.memwrite_p3, dut.regwrite_p4} !== 4'b0) begin
      mismatched++; $display("FAIL reset_ctrl: got %b want 0000", {dut.vld_p2, dut.regwrite_p2, dut.memwrite_p3, dut.regwrite_p4}); end
  endtask

  task automatic test_basic();
    clear_imem();
    dut.imem[0] = f_addi(5'd1, 5'd0, 12'd5);
    dut.imem[1] = f_addi(5'd2, 5'd0, 12'd7);
    dut.imem[2] = f_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
    do_reset();
    start = 1'b1;
    run(3);
    compared++; if (dut.pc !== 32'd12) begin mismatched++; $display("FAIL basic_pc3: got %0d want 12", dut.pc); end
    run(4);
    compared++; if (dut.rf[3] !== 32'd12) begin mismatched++; $display("FAIL basic_x3: got %0d want 12", dut.rf[3]); end
    compared++; if (dut.pc !== 32'd28) begin mismatched++; $display("FAIL basic_pc7: got %0d want 28", dut.pc); end
  endtask

  task automatic test_back_to_back();
    clear_imem();
    dut.imem[0] = f_addi(5'd1, 5'd0, 12'd3);
    dut.imem[1] = f_r(7'h20, 3'b000, 5'd2, 5'd1, 5'd1);
    dut.imem[2] = f_r(7'h01, 3'b000, 5'd4, 5'd1, 5'd1);
    do_reset();
    start = 1'b1;
    run(9);
    compared++; if (dut.rf[2] !== 32'd0) begin mismatched++; $display("FAIL b2b_x2: got %0d want 0", dut.rf[2]); end
    compared++; if (dut.rf[4] !== 32'd9) begin mismatched++; $display("FAIL b2b_x4: got %0d want 9", dut.rf[4]); end
    compared++; if (stalls !== 0) begin mismatched++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
  endtask

  task automatic test_load_use();
    clear_imem();
    dut.dmem[0] = 8'd5;
    dut.dmem[1] = 8'd0;
    dut.dmem[2] = 8'd0;
    dut.dmem[3] = 8'd0;
    for (int i = 4; i < 8; i++) dut.dmem[i] = 8'hAA;
    dut.imem[0] = f_lw(5'd1, 5'd0, 12'd0);
    dut.imem[1] = f_addi(5'd2, 5'd1, 12'd1);
    dut.imem[2] = f_sw(5'd2, 5'd0, 12'd4);
    do_reset();
    start = 1'b1;
    run(10);
    compared++; if (dut.rf[1] !== 32'd5) begin mismatched++; $display("FAIL lu_x1: got %0d want 5", dut.rf[1]); end
    compared++; if (dut.rf[2] !== 32'd6) begin mismatched++; $display("FAIL lu_x2: got %0d want 6", dut.rf[2]); end
    compared++; if ({dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]} !== 32'h0000_0006) begin
      mismatched++; $display("FAIL lu_dmem4: got %h want 00000006", {dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]}); end
    compared++; if (stalls !== 1) begin mismatched++; $display("FAIL lu_stalls: got %0d want 1", stalls); end
    compared++; if (dut.pc !== 32'd36) begin mismatched++; $display("FAIL lu_pc: got %0d want 36", dut.pc); end
`ifdef PIPE_PERF_COUNTERS_EN
    compared++; if (stall_cnt !== 32'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
`endif
  endtask

  task automatic test_branch();
    clear_imem();
    dut.rf[5] = 32'h0;
    dut.rf[7] = 32'h0;
    dut.imem[0] = f_addi(5'd1, 5'd0, 12'd1);
    dut.imem[3] = f_beq(5'd1, 5'd1, 12'd4);
    dut.imem[4] = f_addi(5'd5, 5'd0, 12'd9);
    dut.imem[5] = f_addi(5'd6, 5'd0, 12'd2);
    dut.imem[6] = f_beq(5'd1, 5'd0, 12'd4);
    dut.imem[7] = f_addi(5'd7, 5'd0, 12'd4);
    do_reset();
    start = 1'b1;
    run(13);
    compared++; if (dut.rf[5] !== 32'd0) begin mismatched++; $display("FAIL br_x5: got %0d want 0", dut.rf[5]); end
    compared++; if (dut.rf[6] !== 32'd2) begin mismatched++; $display("FAIL br_x6: got %0d want 2", dut.rf[6]); end
    compared++; if (dut.rf[7] !== 32'd4) begin mismatched++; $display("FAIL br_nt_x7: got %0d want 4", dut.rf[7]); end
    compared++; if (flushes !== 1) begin mismatched++; $display("FAIL br_flushes: got %0d want 1", flushes); end
    compared++; if (dut.pc !== 32'd52) begin mismatched++; $display("FAIL br_pc: got %0d want 52", dut.pc); end
`ifdef PIPE_PERF_COUNTERS_EN
    compared++; if (flush_cnt !== 32'd1) begin mismatched++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
`endif
  endtask

  task automatic test_alu_misc();
    clear_imem();
    dut.rf[31] = 32'h1234_5678;
    dut.imem[0] = f_addi(5'd1, 5'd0, 12'hFF0);
    dut.imem[1] = f_addi(5'd0, 5'd0, 12'd5);
    dut.imem[2] = f_addi(5'd7, 5'd0, 12'd3);
    dut.imem[3] = 32'h0;
    dut.imem[4] = f_srai(5'd2, 5'd1, 5'd2);
    dut.imem[5] = f_addi(5'd3, 5'd0, 12'd28);
    dut.imem[6] = f_r(7'h00, 3'b100, 5'd4, 5'd1, 5'd3);
    dut.imem[7] = f_r(7'h00, 3'b111, 5'd5, 5'd1, 5'd3);
    dut.imem[8] = f_r(7'h00, 3'b001, 5'd6, 5'd3, 5'd3);
    dut.imem[9] = 32'hFFFF_FFFF;
    do_reset();
    start = 1'b1;
    run(15);
    compared++; if (dut.rf[2] !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL misc_srai: got %h want fffffffc", dut.rf[2]); end
    compared++; if (dut.rf[0] !== 32'h0) begin mismatched++; $display("FAIL misc_x0: got %h want 0", dut.rf[0]); end
    compared++; if (dut.rf[7] !== 32'd3) begin mismatched++; $display("FAIL misc_x0_fwd: got %0d want 3", dut.rf[7]); end
    compared++; if (dut.rf[4] !== 32'hFFFF_FFEC) begin mismatched++; $display("FAIL misc_xor: got %h want ffffffec", dut.rf[4]); end
    compared++; if (dut.rf[5] !== 32'h0000_0010) begin mismatched++; $display("FAIL misc_and: got %h want 00000010", dut.rf[5]); end
    compared++; if (dut.rf[6] !== 32'hC000_0000) begin mismatched++; $display("FAIL misc_sll: got %h want c0000000", dut.rf[6]); end
    compared++; if (dut.rf[31] !== 32'h1234_5678) begin mismatched++; $display("FAIL misc_nop_x31: got %h want 12345678", dut.rf[31]); end
  endtask

  task automatic test_start_low();
    clear_imem();
    dut.rf[8] = 32'h0000_DEAD;
    dut.imem[0] = f_addi(5'd8, 5'd0, 12'd77);
    do_reset();
    run(5);
    compared++; if (dut.pc !== 32'h0) begin mismatched++; $display("FAIL idle_pc: got %0d want 0", dut.pc); end
    compared++; if (dut.rf[8] !== 32'h0000_DEAD) begin mismatched++; $display("FAIL idle_x8: got %h want 0000dead", dut.rf[8]); end
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(6);
    compared++; if (dut.pc !== 32'd4) begin mismatched++; $display("FAIL drain_pc: got %0d want 4", dut.pc); end
    compared++; if (dut.rf[8] !== 32'd77) begin mismatched++; $display("FAIL drain_x8: got %0d want 77", dut.rf[8]); end
  endtask

  task automatic test_midrun_reset();
    clear_imem();
    for (int i = 8; i < 12; i++) dut.dmem[i] = 8'h0;
    dut.imem[0] = f_addi(5'd9, 5'd0, 12'd11);
    dut.imem[1] = f_addi(5'd10, 5'd0, 12'd22);
    dut.imem[2] = f_sw(5'd10, 5'd0, 12'd8);
    do_reset();
    start = 1'b1;
    run(8);
    compared++; if (dut.pc !== 32'd32) begin mismatched++; $display("FAIL mid_pc_before: got %0d want 32", dut.pc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++; if (dut.pc !== 32'h0) begin mismatched++; $display("FAIL mid_pc_after: got %0d want 0", dut.pc); end
    compared++; if (dut.rf[9] !== 32'd11) begin mismatched++; $display("FAIL mid_x9: got %0d want 11", dut.rf[9]); end
    compared++; if (dut.dmem[8] !== 8'd22) begin mismatched++; $display("FAIL mid_dmem8: got %0d want 22", dut.dmem[8]); end
    compared++; if (dut.dmem[0] !== 8'd5) begin mismatched++; $display("FAIL mid_dmem0: got %0d want 5", dut.dmem[0]); end
    start = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    stalls     = 0;
    flushes    = 0;
    rst        = 1'b1;
    start      = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_alu_misc();
    test_start_low();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
